// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// Optional build macro: ARB_STARVE_GUARD_EN (fetch starvation guard).
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W              = 32;
  localparam int ARB_DATA_W              = 32;
  localparam int ARB_MAX_DATA_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IFETCH,
    ARB_DATA
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Grant selection for the memory port arbiter.
// Data normally wins because the MEM-stage instruction is older; streak_hit
// lets a waiting fetch through when the starvation guard fires.
module arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic streak_hit,
  output logic grant_i,
  output logic grant_d
);

  // Pick at most one requester for this IDLE cycle
  always_comb begin
    grant_d = d_req & ~(streak_hit & i_req);
    grant_i = i_req & (~d_req | streak_hit);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// One request is owned at a time; the payload is latched at grant and held
// until mem_ack, and an IDLE bubble separates consecutive transactions.
// Optional build macro: ARB_STARVE_GUARD_EN bounds how many data grants may
// pass a waiting fetch (MAX_DATA_STREAK).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = ARB_ADDR_W,
  parameter int DATA_W          = ARB_DATA_W,
  parameter int MAX_DATA_STREAK = ARB_MAX_DATA_STREAK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t state_q, state_d;
  mem_cmd_t   cmd_q, cmd_d;
  logic       grant_i, grant_d;
  logic       streak_hit;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Guard fires once the data side has taken its allowance of grants
  always_comb begin
    streak_hit = (streak_q == STREAK_W'(MAX_DATA_STREAK));
  end
`else
  // Strict data priority: the fetch never jumps ahead of a data request
  always_comb begin
    streak_hit = 1'b0;
  end
`endif

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .streak_hit (streak_hit),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // State, latched payload and streak register; reset abandons any transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      cmd_q   <= '0;
`ifdef ARB_STARVE_GUARD_EN
      streak_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
`ifdef ARB_STARVE_GUARD_EN
      streak_q <= streak_d;
`endif
    end
  end

  // Next-state: requests are sampled only in IDLE, busy states wait for mem_ack
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
`ifdef ARB_STARVE_GUARD_EN
    streak_d = streak_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d     = ARB_DATA;
          cmd_d.we    = d_we;
          cmd_d.addr  = d_addr;
          cmd_d.wdata = d_wdata;
`ifdef ARB_STARVE_GUARD_EN
          streak_d = i_req ? streak_q + 1'b1 : '0;
`endif
        end else if (grant_i) begin
          state_d     = ARB_IFETCH;
          cmd_d.we    = 1'b0;
          cmd_d.addr  = i_addr;
          cmd_d.wdata = '0;
`ifdef ARB_STARVE_GUARD_EN
          streak_d = '0;
`endif
        end
      end
      ARB_IFETCH, ARB_DATA: begin
        if (mem_ack) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Memory side and completion outputs; valids are combinational with mem_ack
  always_comb begin
    mem_req   = (state_q != ARB_IDLE);
    mem_we    = cmd_q.we;
    mem_addr  = cmd_q.addr;
    mem_wdata = cmd_q.wdata;
    i_valid   = (state_q == ARB_IFETCH) & mem_ack;
    d_valid   = (state_q == ARB_DATA) & mem_ack;
    i_rdata   = i_valid ? mem_rdata : '0;
    d_rdata   = (d_valid & ~cmd_q.we) ? mem_rdata : '0;
    stall_if  = i_req & ~i_valid & ~reset;
    stall_mem = d_req & ~d_valid & ~reset;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// With ARB_STARVE_GUARD_EN defined the grant-order test expects the guard
// pattern for MAX_DATA_STREAK=2; otherwise it expects strict data priority.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_valid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;

   int testsRun;
   int testsFailed;

   mem_port_arbiter #(
      .ADDR_W          (32),
      .DATA_W          (32),
      .MAX_DATA_STREAK (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_valid   (i_valid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .stall_if  (stall_if),
      .stall_mem (stall_mem)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it if the observed value is wrong
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock edge and settle a little past it
   task automatic applyStimulus();
      @(posedge clk);
      #2;
   endtask

   // Drop all requester and memory inputs
   task automatic clearInputs();
      i_req     = 1'b0;
      i_addr    = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
   endtask

   // Pulse reset away from the clock edge
   task automatic pulseReset();
      #1 reset = 1'b1;
      #3 reset = 1'b0;
      #1;
   endtask

   // Main directed sequence
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      clearInputs();
      reset = 1'b1;
      i_req = 1'b1;
      #12;
      checkOutput("rst_mem_req",  {63'd0, mem_req},  64'd0);
      checkOutput("rst_mem_we",   {63'd0, mem_we},   64'd0);
      checkOutput("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      checkOutput("rst_i_valid",  {63'd0, i_valid},  64'd0);
      checkOutput("rst_stall_if", {63'd0, stall_if}, 64'd0);
      i_req = 1'b0;
      reset = 1'b0;
      applyStimulus();

      // Lone fetch, memory acks two cycles after mem_req
      i_req  = 1'b1;
      i_addr = 32'h8;
      #1;
      checkOutput("lf_stall_raise", {63'd0, stall_if}, 64'd1);
      checkOutput("lf_req_bubble",  {63'd0, mem_req},  64'd0);
      applyStimulus();
      checkOutput("lf_mem_req",  {63'd0, mem_req},  64'd1);
      checkOutput("lf_mem_addr", {32'd0, mem_addr}, 64'h8);
      checkOutput("lf_mem_we",   {63'd0, mem_we},   64'd0);
      applyStimulus();
      checkOutput("lf_wait_valid", {63'd0, i_valid},  64'd0);
      checkOutput("lf_wait_stall", {63'd0, stall_if}, 64'd1);
      applyStimulus();
      mem_ack   = 1'b1;
      mem_rdata = 32'h00300213;
      #1;
      checkOutput("lf_i_valid",    {63'd0, i_valid},  64'd1);
      checkOutput("lf_i_rdata",    {32'd0, i_rdata},  64'h00300213);
      checkOutput("lf_stall_done", {63'd0, stall_if}, 64'd0);
      checkOutput("lf_d_valid",    {63'd0, d_valid},  64'd0);
      applyStimulus();
      clearInputs();
      #1;
      checkOutput("lf_idle_req",    {63'd0, mem_req},  64'd0);
      checkOutput("lf_idle_valid",  {63'd0, i_valid},  64'd0);
      checkOutput("lf_idle_rdata",  {32'd0, i_rdata},  64'd0);

      // Simultaneous requests: data first, fetch after the bubble
      i_req  = 1'b1;
      i_addr = 32'h4;
      d_req  = 1'b1;
      d_addr = 32'd20;
      applyStimulus();
      checkOutput("sim_addr_d",  {32'd0, mem_addr}, 64'd20);
      checkOutput("sim_we_d",    {63'd0, mem_we},   64'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h6D;
      #1;
      checkOutput("sim_d_valid", {63'd0, d_valid},  64'd1);
      checkOutput("sim_d_rdata", {32'd0, d_rdata},  64'h6D);
      checkOutput("sim_i_early", {63'd0, i_valid},  64'd0);
      checkOutput("sim_stall_if",{63'd0, stall_if}, 64'd1);
      applyStimulus();
      d_req   = 1'b0;
      mem_ack = 1'b0;
      #1;
      checkOutput("sim_bubble",  {63'd0, mem_req},  64'd0);
      applyStimulus();
      checkOutput("sim_addr_i",  {32'd0, mem_addr}, 64'h4);
      mem_ack   = 1'b1;
      mem_rdata = 32'h13;
      #1;
      checkOutput("sim_i_valid", {63'd0, i_valid},  64'd1);
      checkOutput("sim_i_rdata", {32'd0, i_rdata},  64'h13);
      applyStimulus();
      clearInputs();

      // Store held stable until ack, load data suppressed
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h10;
      d_wdata = 32'hDEADBEEF;
      applyStimulus();
      checkOutput("st_mem_we",    {63'd0, mem_we},    64'd1);
      checkOutput("st_wdata",     {32'd0, mem_wdata}, 64'hDEADBEEF);
      d_wdata = 32'h12345678;
      applyStimulus();
      checkOutput("st_wdata_hold",{32'd0, mem_wdata}, 64'hDEADBEEF);
      checkOutput("st_stall",     {63'd0, stall_mem}, 64'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h55;
      #1;
      checkOutput("st_d_valid",   {63'd0, d_valid},   64'd1);
      checkOutput("st_d_rdata",   {32'd0, d_rdata},   64'd0);
      applyStimulus();
      clearInputs();

      // Payload stability: address change after grant does not propagate
      d_req  = 1'b1;
      d_addr = 32'd20;
      applyStimulus();
      d_addr = 32'd24;
      applyStimulus();
      checkOutput("ps_addr_hold", {32'd0, mem_addr}, 64'd20);
      mem_ack   = 1'b1;
      mem_rdata = 32'hA5;
      #1;
      checkOutput("ps_addr_ack",  {32'd0, mem_addr}, 64'd20);
      checkOutput("ps_d_rdata",   {32'd0, d_rdata},  64'hA5);
      applyStimulus();
      clearInputs();

      // Reset mid-transaction drops mem_req without a clock edge
      d_req  = 1'b1;
      d_addr = 32'h30;
      applyStimulus();
      checkOutput("rm_req_before", {63'd0, mem_req}, 64'd1);
      reset   = 1'b1;
      mem_ack = 1'b1;
      #1;
      checkOutput("rm_req_drop",   {63'd0, mem_req}, 64'd0);
      checkOutput("rm_no_valid",   {63'd0, d_valid}, 64'd0);
      #1 reset = 1'b0;
      clearInputs();
      applyStimulus();
      checkOutput("rm_idle",       {63'd0, mem_req}, 64'd0);

      // Ack while idle is ignored
      mem_ack = 1'b1;
      #1;
      checkOutput("ia_i_valid", {63'd0, i_valid}, 64'd0);
      checkOutput("ia_d_valid", {63'd0, d_valid}, 64'd0);
      applyStimulus();
      mem_ack = 1'b0;
      checkOutput("ia_mem_req", {63'd0, mem_req}, 64'd0);

      // Grant order with data held and a fetch waiting
      pulseReset();
      i_req  = 1'b1;
      i_addr = 32'h200;
      d_req  = 1'b1;
      d_addr = 32'h100;
      for (int k = 0; k < 6; k++) begin
         logic [31:0] expAddr;
`ifdef ARB_STARVE_GUARD_EN
         expAddr = (k == 2 || k == 5) ? 32'h200 : 32'h100;
`else
         expAddr = 32'h100;
`endif
         applyStimulus();
         checkOutput($sformatf("order_%0d", k), {32'd0, mem_addr}, {32'd0, expAddr});
         mem_ack = 1'b1;
         #1;
         checkOutput($sformatf("order_iv_%0d", k), {63'd0, i_valid},
                     {63'd0, (expAddr == 32'h200)});
         applyStimulus();
         mem_ack = 1'b0;
      end
      clearInputs();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Absolute time limit so the bench can never hang
   initial begin
      #100000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
